mem_sequencer: RTL and testbench

- Multi-cycle sequencer that places the single-cycle MIPS datapath on one shared, variable-latency, single-ported memory.
- Each instruction runs in order: instruction fetch, then an optional load/store, then commit.
- Latches the instruction word and the load data for the datapath.
- Drives a one-cycle commit strobe (cpu_en) that gates the PC register and register-file writes.
- Includes an ack watchdog, alignment checks and a retired-instruction counter.

---
 rtl/mem_sequencer_pkg.sv | 17 +
 rtl/ack_watchdog.sv | 26 ++
 rtl/mem_sequencer.sv | 122 ++++++++++++
 tb/tb_mem_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared state encoding and fault codes for the memory sequencer.
package mem_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    DATA   = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_IFETCH_ALIGN = 2'd1;
  localparam logic [1:0] ERR_DATA_ALIGN   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT      = 2'd3;

endpackage

// File: rtl/ack_watchdog.sv
// Counts request cycles without ack; flags expiry on the cycle the count would reach TIMEOUT.
module ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear || ack) count <= '0;
    else if (busy && count != LIM) count <= count + 1'b1;
  end

  // An ack on the expiring edge wins, so ack masks expiry.
  assign expired = (TIMEOUT > 0) && busy && !ack && (count == LIM);

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle fetch / data / commit sequencer placing a MIPS datapath on one shared memory.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       data,
  input  logic              wmem,
  input  logic              m2reg,
  output logic [31:0]       inst,
  output logic [31:0]       mem,
  output logic              cpu_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  retired
);

  state_t     state, next_state;
  logic [1:0] next_code;
  logic       ack, expired, wd_clear, is_mem, is_load;
  logic       load_inst, load_mem, commit;

  assign is_mem  = wmem | m2reg;
  assign is_load = m2reg & ~wmem;

  // Request outputs decode straight from state so the handshake holds them stable.
  assign mem_req   = !reset && ((state == FETCH && pc[1:0] == 2'b00) || state == DATA);
  assign mem_we    = mem_req && state == DATA && wmem;
  assign mem_addr  = (state == DATA) ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
  assign mem_wdata = data;
  assign ack       = mem_ack && mem_req;
  assign cpu_en    = commit && !reset;
  assign err       = (state == HALT);

  always_comb begin
    next_state = state;
    next_code  = err_code;
    load_inst  = 1'b0;
    load_mem   = 1'b0;
    commit     = 1'b0;
    case (state)
      FETCH: begin
        if (pc[1:0] != 2'b00) begin
          next_state = HALT;
          next_code  = ERR_IFETCH_ALIGN;
        end else if (ack) begin
          next_state = DECODE;
          load_inst  = 1'b1;
        end else if (expired) begin
          next_state = HALT;
          next_code  = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        if (!is_mem) begin
          commit     = 1'b1;
          next_state = FETCH;
        end else if (alu_out[1:0] != 2'b00) begin
          next_state = HALT;
          next_code  = ERR_DATA_ALIGN;
        end else begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (ack) begin
          load_mem   = is_load;
          next_state = COMMIT;
        end else if (expired) begin
          next_state = HALT;
          next_code  = ERR_TIMEOUT;
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  assign wd_clear = (next_state != state) && (next_state == FETCH || next_state == DATA);

  ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .busy    (mem_req),
    .ack     (ack),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      inst     <= '0;
      mem      <= '0;
      err_code <= ERR_NONE;
      retired  <= '0;
    end else begin
      state    <= next_state;
      err_code <= next_code;
      if (load_inst) inst <= mem_rdata;
      if (load_mem)  mem  <= mem_rdata;
      if (commit)    retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized bench: an instruction-level latency model predicts every cycle of the bus and commit outputs.
module tb_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0, alu_out = '0, data = '0, mem_rdata = '0;
  logic        wmem = 1'b0, m2reg = 1'b0, mem_ack = 1'b0;
  logic [31:0] inst, mem, mem_addr, mem_wdata, retired;
  logic        cpu_en, mem_req, mem_we, err;
  logic [1:0]  err_code;

  mem_sequencer #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .pc(pc), .alu_out(alu_out), .data(data),
    .wmem(wmem), .m2reg(m2reg), .inst(inst), .mem(mem), .cpu_en(cpu_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .err_code(err_code),
    .retired(retired)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model state: expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        exp_req = 0, exp_we = 0, exp_cpu = 0, exp_err = 0;
  logic [1:0]  exp_code = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_inst = 0, exp_mem = 0, exp_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic compare();
    chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
    if (exp_req) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
    end
    chk("cpu_en", {31'd0, cpu_en}, {31'd0, exp_cpu});
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("err_code", {30'd0, err_code}, {30'd0, exp_code});
    chk("inst", inst, exp_inst);
    chk("mem", mem, exp_mem);
    chk("retired", retired, exp_ret);
  endtask

  // Inputs change 1 unit after a rising edge; outputs are compared on the falling edge.
  task automatic tick();
    @(negedge clock);
    if (chk_en) compare();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cyc(input logic req, input logic we, input logic [31:0] addr, input logic cpu);
    exp_req = req; exp_we = we; exp_addr = addr; exp_cpu = cpu;
  endtask

  task automatic noise();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; chk_en = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    tick();
    exp_inst = 0; exp_mem = 0; exp_ret = 0; exp_err = 0; exp_code = 0;
    set_cyc(0, 0, 0, 0);
    chk_en = 1'b1;
    for (int i = 1; i < n; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
    end
    reset = 1'b0; mem_ack = 1'b0;
  endtask

  // One instruction: fetch (fw wait cycles), decode, optional data (dw waits), commit.
  task automatic do_instr(input logic [31:0] p, input logic [31:0] iw, input logic w, input logic m,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] ldv,
                          input int fw, input int dw);
    pc = p; alu_out = a; data = d; wmem = w; m2reg = m; chk_en = 1'b1;
    for (int k = 0; k <= fw; k++) begin
      mem_ack   = (k == fw);
      mem_rdata = (k == fw) ? iw : $urandom;
      set_cyc(1, 0, p, 0);
      tick();
    end
    exp_inst = iw;
    noise();
    set_cyc(0, 0, 0, !(w | m));
    tick();
    if (!(w | m)) begin
      exp_ret++;
      return;
    end
    if (a[1:0] != 2'b00) return;
    for (int k = 0; k <= dw; k++) begin
      mem_ack   = (k == dw);
      mem_rdata = (k == dw) ? ldv : $urandom;
      set_cyc(1, w, a, 0);
      exp_wdata = d;
      tick();
    end
    if (m && !w) exp_mem = ldv;
    noise();
    set_cyc(0, 0, 0, 1);
    tick();
    exp_ret++;
  endtask

  task automatic halt_cycles(input int n, input logic [1:0] code);
    for (int i = 0; i < n; i++) begin
      noise();
      set_cyc(0, 0, 0, 0);
      exp_err = 1; exp_code = code;
      tick();
    end
  endtask

  initial begin
    do_reset(2);
    chk("rst_retired", retired, 32'd0);

    // addi, zero-wait
    do_instr(32'h0, 32'h20080005, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    chk("addi_retired", retired, 32'd1);
    chk("addi_inst", inst, 32'h20080005);

    // lw, ack in third request cycle
    do_instr(32'h4, 32'h8C090010, 0, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
    chk("lw_mem", mem, 32'hDEADBEEF);
    chk("lw_retired", retired, 32'd2);

    // sw, zero-wait
    do_instr(32'h8, 32'hAC0A0024, 1, 0, 32'h24, 32'h12345678, 32'h0, 0, 0);
    chk("sw_retired", retired, 32'd3);
    chk("sw_mem_kept", mem, 32'hDEADBEEF);

    // misaligned fetch
    pc = 32'h6; mem_ack = 1'b1; mem_rdata = $urandom;
    set_cyc(0, 0, 0, 0);
    tick();
    halt_cycles(20, 2'd1);
    chk("ifetch_code", {30'd0, err_code}, 32'd1);
    do_reset(2);
    chk("clr_err", {31'd0, err}, 32'd0);

    // misaligned data address
    do_instr(32'h40, 32'h8C0B0003, 0, 1, 32'h3, 32'h0, 32'h0, 0, 0);
    halt_cycles(5, 2'd2);
    chk("dalign_code", {30'd0, err_code}, 32'd2);
    do_reset(2);

    // fetch timeout: four request cycles without ack
    pc = 32'h80;
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'b0;
      set_cyc(1, 0, 32'h80, 0);
      tick();
    end
    halt_cycles(5, 2'd3);
    chk("timeout_code", {30'd0, err_code}, 32'd3);
    do_reset(2);

    // ack on the fourth request cycle wins over the watchdog
    do_instr(32'h80, 32'h00000020, 0, 1, 32'h84, 32'h0, 32'hCAFEF00D, 3, 3);
    chk("edge_err", {31'd0, err}, 32'd0);
    chk("edge_retired", retired, 32'd1);

    // reset during a data wait abandons the load; the late ack is ignored
    pc = 32'h100; alu_out = 32'h40; wmem = 0; m2reg = 1;
    mem_ack = 1'b1; mem_rdata = 32'h8C0C0040;
    set_cyc(1, 0, 32'h100, 0);
    tick();
    exp_inst = 32'h8C0C0040;
    mem_ack = 1'b0;
    set_cyc(0, 0, 0, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b0;
      set_cyc(1, 0, 32'h40, 0);
      tick();
    end
    do_reset(2);
    chk("abort_retired", retired, 32'd0);
    chk("abort_inst", inst, 32'd0);
    chk("abort_mem", mem, 32'd0);

    // randomized instruction mix
    for (int n = 0; n < 300; n++) begin
      int ty;
      logic [31:0] rp, ra;
      ty = $urandom_range(0, 3);
      rp = $urandom & 32'hFFFF_FFFC;
      ra = $urandom & 32'hFFFF_FFFC;
      do_instr(rp, $urandom, (ty >= 2), (ty == 1 || ty == 3), ra, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3));
    end
    chk("rand_retired", retired, 32'd300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench ran out of time");
    $fatal(1, "bench timeout");
  end

endmodule
